// File: rtl/adder_arbiter.sv
// Shares one registered WIDTH-bit adder among N requesters with round-robin arbitration.
// Single response register tagged with the owning requester index.
module adder_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned IDW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_a,
    input  logic [N*WIDTH-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_z,
    output logic                 rsp_cout,
    output logic [31:0]          op_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q;
    logic             can_accept_c;
    logic             grant_c;
    logic [IDW-1:0]   grant_idx_c;
    int unsigned      idx_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic [WIDTH:0]   sum_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        state_d      = state_q;
        can_accept_c = (state_q == EMPTY) || rsp_ready;
        grant_c      = 1'b0;
        grant_idx_c  = '0;
        idx_c        = 0;
        req_ready    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx_c = (32'(last_grant_q) + k) % N;
            if (can_accept_c && !reset && !grant_c && req_valid[idx_c]) begin
                grant_c     = 1'b1;
                grant_idx_c = IDW'(idx_c);
            end
        end
        req_ready[grant_idx_c] = grant_c;

        case (state_q)
            EMPTY: if (grant_c) state_d = FULL;
            FULL:  if (rsp_ready && !grant_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign a_sel_c = req_a[32'(grant_idx_c) * WIDTH +: WIDTH];
    assign b_sel_c = req_b[32'(grant_idx_c) * WIDTH +: WIDTH];
    assign sum_c   = {1'b0, a_sel_c} + {1'b0, b_sel_c};

    // Response register, arbiter pointer and transfer counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id       <= '0;
            rsp_z        <= '0;
            rsp_cout     <= 1'b0;
            op_count     <= '0;
            last_grant_q <= IDW'(N - 1);
        end else if (grant_c) begin
            rsp_id       <= grant_idx_c;
            rsp_z        <= sum_c[WIDTH-1:0];
            rsp_cout     <= sum_c[WIDTH];
            op_count     <= op_count + 32'd1;
            last_grant_q <= grant_idx_c;
        end
    end

    assign rsp_valid = (state_q == FULL);

endmodule
